// File: rtl/sequence_presenter_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the memory-game sequencing path:
//   - display ROM-select encodings
//   - sequence_presenter state enum
//   - LFSR default seed and single-step helpers (x^8+x^6+x^5+x^4+1)
// -----------------------------------------------------------------------------
package game_pkg;

    localparam logic [2:0] DISP_INTRO    = 3'b100;
    localparam logic [2:0] DISP_GAMEOVER = 3'b101;
    localparam logic [2:0] DISP_WIN      = 3'b111;

    localparam logic [7:0] LFSR_DEFAULT_SEED = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        ON   = 2'd2,
        OFF  = 2'd3
    } state_e;

    // One Fibonacci shift: taps at stages 8,6,5,4 feed bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    // The two LSBs the register will hold after one shift.
    function automatic logic [1:0] lfsr_next_sym(input logic [7:0] cur);
        return {cur[0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

endpackage

// File: rtl/sequence_presenter_if.sv
// -----------------------------------------------------------------------------
// sequence_presenter_if
// Command/readback/display bundle between the game FSM + video mux (master)
// and sequence_presenter (slave).
//   new_pattern, play, abort : command pulses
//   level                    : current game level
//   seed_load, seed          : LFSR seeding
//   rd_idx / rd_sym          : pattern readback for the key checker
//   busy, done               : status
//   display, clear           : ROM select and screen-blank request
// -----------------------------------------------------------------------------
interface sequence_presenter_if #(
    parameter int MAX_LEN = 8
);
    localparam int IDX_W = $clog2(MAX_LEN);

    logic             new_pattern;
    logic             play;
    logic             abort;
    logic [2:0]       level;
    logic             seed_load;
    logic [7:0]       seed;
    logic [IDX_W-1:0] rd_idx;
    logic [1:0]       rd_sym;
    logic             busy;
    logic             done;
    logic [2:0]       display;
    logic             clear;

    modport master (
        output new_pattern, play, abort, level, seed_load, seed, rd_idx,
        input  rd_sym, busy, done, display, clear
    );

    modport slave (
        input  new_pattern, play, abort, level, seed_load, seed, rd_idx,
        output rd_sym, busy, done, display, clear
    );

endinterface

// File: rtl/sequence_presenter_lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), shifts left, feedback into bit 0.
//   clk, reset : clock, synchronous active-high reset (to LFSR_DEFAULT_SEED)
//   load, seed : load seed; an all-zero seed is replaced by the default
//   en         : advance one step
//   q          : current register value
// -----------------------------------------------------------------------------
module lfsr8
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Next value: load wins over shift; zero would lock the register up.
    always_comb begin
        q_d = q_q;
        if (load) begin
            if (seed == 8'h00) begin
                q_d = LFSR_DEFAULT_SEED;
            end else begin
                q_d = seed;
            end
        end else if (en) begin
            q_d = lfsr_step(q_q);
        end else begin
            q_d = q_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= LFSR_DEFAULT_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sequence_presenter.sv
// -----------------------------------------------------------------------------
// sequence_presenter
// Generates a MAX_LEN-entry pattern of 2-bit symbols from an LFSR and plays the
// first L = min(level+1, MAX_LEN) symbols: each symbol is shown for ON_CYCLES,
// then the screen is cleared for OFF_CYCLES.
//   clk, reset : clock, synchronous active-high reset
//   bus        : sequence_presenter_if.slave (commands, readback, display)
// rd_sym is a combinational read of the pattern store; all other outputs are
// registered.
// -----------------------------------------------------------------------------
module sequence_presenter
    import game_pkg::*;
#(
    parameter int MAX_LEN    = 8,
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000,
    parameter int CNT_W      = $clog2(ON_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    sequence_presenter_if.slave  bus
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(MAX_LEN - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] last_q, last_d;      // index of final symbol to play
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [2:0]       display_q, display_d;
    logic             clear_q, clear_d;
    logic [1:0]       pattern_q [MAX_LEN];

    logic [7:0]       lfsr_s;
    logic             lfsr_load_s;
    logic             lfsr_en_s;
    logic [1:0]       gen_sym_s;
    logic [IDX_W-1:0] last_lvl_s;

    assign lfsr_load_s = bus.seed_load && (state_q == IDLE);
    assign lfsr_en_s   = (state_q == GEN);
    assign gen_sym_s   = lfsr_next_sym(lfsr_s);

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (lfsr_load_s),
        .seed  (bus.seed),
        .en    (lfsr_en_s),
        .q     (lfsr_s)
    );

    // Clamp level+1 to MAX_LEN, expressed as the last index to play.
    always_comb begin
        last_lvl_s = IDX_MAX;
        if (32'(bus.level) >= MAX_LEN - 1) begin
            last_lvl_s = IDX_MAX;
        end else begin
            last_lvl_s = IDX_W'(bus.level);
        end
    end

    // Next-state logic for the sequencer FSM, index and dwell counter.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // new_pattern outranks play; the loser is dropped.
                if (bus.new_pattern) begin
                    state_d = GEN;
                    idx_d   = '0;
                end else if (bus.play) begin
                    state_d = ON;
                    idx_d   = '0;
                    cnt_d   = '0;
                    last_d  = last_lvl_s;
                end else begin
                    state_d = IDLE;
                end
            end
            GEN: begin
                // abort is deliberately ignored so the pattern is never partial.
                if (idx_q == IDX_MAX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ON: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == ON_LAST) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OFF: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == OFF_LAST) begin
                    cnt_d = '0;
                    if (idx_q == last_q) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ON;
                        idx_d   = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs can be registered
    // without an extra cycle of latency.
    always_comb begin
        display_d = DISP_INTRO;
        clear_d   = 1'b0;
        busy_d    = (state_d != IDLE);
        if ((state_d == ON) || (state_d == OFF)) begin
            display_d = {1'b0, pattern_q[idx_d]};
            clear_d   = (state_d == OFF);
        end else begin
            display_d = DISP_INTRO;
            clear_d   = 1'b0;
        end
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            last_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            display_q <= DISP_INTRO;
            clear_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            display_q <= display_d;
            clear_q   <= clear_d;
        end
    end

    // Pattern store: one entry written per GEN cycle, zeroed on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                pattern_q[i] <= 2'b00;
            end
        end else if (state_q == GEN) begin
            pattern_q[idx_q] <= gen_sym_s;
        end else begin
            for (int i = 0; i < MAX_LEN; i++) begin
                pattern_q[i] <= pattern_q[i];
            end
        end
    end

    assign bus.rd_sym  = pattern_q[bus.rd_idx];
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.display = display_q;
    assign bus.clear   = clear_q;

endmodule

// File: tb/tb_sequence_presenter.sv
// -----------------------------------------------------------------------------
// tb_sequence_presenter
// Self-checking bench for sequence_presenter with MAX_LEN=8, ON_CYCLES=4,
// OFF_CYCLES=2. A behavioural model (polynomial LFSR + pattern array) predicts
// the pattern; expected display traces are built from the play rules.
// -----------------------------------------------------------------------------
module tb_sequence_presenter;

    localparam int ML   = 8;
    localparam int ONC  = 4;
    localparam int OFFC = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sequence_presenter_if #(.MAX_LEN(ML)) bus ();

    sequence_presenter #(
        .MAX_LEN    (ML),
        .ON_CYCLES  (ONC),
        .OFF_CYCLES (OFFC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0] m_lfsr;
    logic [1:0] m_pat [ML];
    logic [1:0] saved_pat [ML];
    logic [3:0] trace_q [$];
    logic [3:0] prev_trace [$];

    typedef struct {
        logic [2:0] level;
        int         exp_len;
    } play_vec_t;
    play_vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Polynomial x^8+x^6+x^5+x^4+1: feedback is XOR of the tapped stages.
    function automatic logic [7:0] m_step(input logic [7:0] v);
        int   taps [4] = '{8, 6, 5, 4};
        logic fb = 1'b0;
        foreach (taps[k]) fb = fb ^ v[taps[k] - 1];
        return {v[6:0], fb};
    endfunction

    task automatic model_reset;
        m_lfsr = 8'hA5;
        for (int i = 0; i < ML; i++) m_pat[i] = 2'b00;
    endtask

    task automatic model_gen;
        for (int i = 0; i < ML; i++) begin
            m_lfsr   = m_step(m_lfsr);
            m_pat[i] = m_lfsr[1:0];
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_pattern(input string tag);
        for (int i = 0; i < ML; i++) begin
            bus.rd_idx = 3'(i);
            #1;
            chk($sformatf("%s_idx%0d", tag, i), 32'(bus.rd_sym), 32'(m_pat[i]));
        end
    endtask

    task automatic seed_load_t(input logic [7:0] s);
        bus.seed      = s;
        bus.seed_load = 1'b1;
        tick();
        bus.seed_load = 1'b0;
        m_lfsr = (s == 8'h00) ? 8'hA5 : s;
    endtask

    // Issue new_pattern (optionally with play in the same cycle) and time busy.
    task automatic gen_t(input bit with_play);
        int n = 0;
        bus.new_pattern = 1'b1;
        bus.play        = with_play;
        tick();
        bus.new_pattern = 1'b0;
        bus.play        = 1'b0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("gen_busy_len", 32'(n), 32'(ML));
        model_gen();
    endtask

    // Play and compare {clear,display} every cycle against the model trace.
    task automatic play_t(input logic [2:0] lvl, input int len, input int abort_at, input bit mid_play);
        logic [3:0] exp_q [$];
        bit aborted = 1'b0;
        for (int i = 0; i < len; i++) begin
            repeat (ONC)  exp_q.push_back({1'b0, 1'b0, m_pat[i]});
            repeat (OFFC) exp_q.push_back({1'b1, 1'b0, m_pat[i]});
        end
        trace_q.delete();
        bus.level = lvl;
        bus.play  = 1'b1;
        tick();
        bus.play  = 1'b0;
        bus.level = 3'($urandom_range(0, 7));
        for (int c = 0; c < exp_q.size(); c++) begin
            trace_q.push_back({bus.clear, bus.display});
            chk($sformatf("play_l%0d_c%0d", lvl, c), 32'({bus.clear, bus.display}), 32'(exp_q[c]));
            chk($sformatf("play_busy_l%0d_c%0d", lvl, c), 32'({bus.busy, bus.done}), 32'(2'b10));
            if (abort_at == c + 1) bus.abort = 1'b1;
            if (mid_play && c == 5) begin
                bus.play        = 1'b1;
                bus.new_pattern = 1'b1;
                bus.level       = 3'd0;
            end
            tick();
            bus.abort       = 1'b0;
            bus.play        = 1'b0;
            bus.new_pattern = 1'b0;
            if (abort_at == c + 1) begin
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            chk($sformatf("end_done_l%0d", lvl),
                32'({bus.display, bus.clear, bus.busy, bus.done}), 32'(6'b100_0_0_1));
            tick();
            chk($sformatf("end_idle_l%0d", lvl),
                32'({bus.display, bus.clear, bus.busy, bus.done}), 32'(6'b100_0_0_0));
        end else begin
            chk($sformatf("abort_idle_l%0d", lvl),
                32'({bus.display, bus.clear, bus.busy, bus.done}), 32'(6'b100_0_0_0));
            for (int k = 0; k < 10; k++) begin
                tick();
                chk($sformatf("abort_nodone_%0d", k), 32'(bus.done), 32'(0));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int diffs;
        bus.new_pattern = 1'b0;
        bus.play        = 1'b0;
        bus.abort       = 1'b0;
        bus.level       = 3'd0;
        bus.seed_load   = 1'b0;
        bus.seed        = 8'h00;
        bus.rd_idx      = 3'd0;
        reset           = 1'b1;
        @(negedge clk);

        // reset then idle
        do_reset(2);
        chk("reset_outs", 32'({bus.display, bus.clear, bus.busy, bus.done}), 32'(6'b100_0_0_0));
        check_pattern("reset_pat");

        // generation with zero seed (substituted by A5), then seed 01
        seed_load_t(8'h00);
        gen_t(1'b0);
        check_pattern("gen_a5");
        for (int i = 0; i < ML; i++) saved_pat[i] = m_pat[i];
        seed_load_t(8'h01);
        gen_t(1'b0);
        check_pattern("gen_01");
        diffs = 0;
        for (int i = 0; i < ML; i++) begin
            bus.rd_idx = 3'(i);
            #1;
            if (bus.rd_sym !== saved_pat[i]) diffs++;
        end
        chk("gen_01_differs", 32'(diffs != 0), 32'(1));

        // table-driven playback lengths incl. clamp
        vecs[0] = '{level: 3'd2, exp_len: 3};
        vecs[1] = '{level: 3'd0, exp_len: 1};
        vecs[2] = '{level: 3'd5, exp_len: 6};
        vecs[3] = '{level: 3'd7, exp_len: 8};
        vecs[4] = '{level: 3'd4, exp_len: 5};
        for (int v = 0; v < 5; v++) begin
            play_t(vecs[v].level, vecs[v].exp_len, 0, 1'b0);
        end

        // replay at level 7 with commands injected mid-run
        play_t(3'd7, 8, 0, 1'b1);
        prev_trace = trace_q;
        play_t(3'd7, 8, 0, 1'b1);
        n = (prev_trace.size() == trace_q.size()) ? 1 : 0;
        for (int i = 0; i < trace_q.size() && n == 1; i++) begin
            if (prev_trace[i] !== trace_q[i]) n = 0;
        end
        chk("replay_identical", 32'(n), 32'(1));

        // new_pattern and play together: GEN only
        gen_t(1'b1);
        check_pattern("gen_sim");
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("sim_noplay_%0d", k),
                32'({bus.display, bus.busy, bus.done}), 32'(5'b100_0_0));
            tick();
        end

        // abort on the 3rd ON cycle
        play_t(3'd2, 3, 3, 1'b0);

        // reset during OFF
        bus.level = 3'd2;
        bus.play  = 1'b1;
        tick();
        bus.play = 1'b0;
        n = 0;
        while (bus.clear !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("reach_off", 32'(bus.clear), 32'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        chk("midreset_outs", 32'({bus.display, bus.clear, bus.busy, bus.done}), 32'(6'b100_0_0_0));
        check_pattern("midreset_pat");
        play_t(3'd2, 3, 0, 1'b0);

        // randomized generate/play rounds against the model
        for (int it = 0; it < 6; it++) begin
            logic [2:0] lvl;
            int ab;
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 3) == 0) seed_load_t(8'h00);
                else                           seed_load_t(8'($urandom_range(1, 255)));
            end
            gen_t(1'b0);
            check_pattern($sformatf("rand%0d_pat", it));
            lvl = 3'($urandom_range(0, 7));
            ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (int'(lvl) + 1) * (ONC + OFFC)) : 0;
            play_t(lvl, int'(lvl) + 1, ab, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequence_presenter.md
Name: sequence_presenter

Overview:
Sequencing controller for the memory-game VGA digit path. It generates a pseudo-random pattern of 2-bit symbols and plays the first level+1 symbols on the display-select/clear lines with fixed on/off timing. It sits between the game FSM, which issues play/replay/new-pattern commands and reads symbols back to check key presses, and the ROM-select mux feeding the video driver.

Parameters:
MAX_LEN, 8, pattern storage depth and maximum playable length (power of 2).
ON_CYCLES, 25000000, clk cycles each symbol is shown (0.5 s at 50 MHz).
OFF_CYCLES, 12500000, clk cycles of cleared screen after each symbol.
CNT_W, $clog2(ON_CYCLES+1), width of the dwell counter (derived; must also hold OFF_CYCLES).

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  synchronous, active-high
new_pattern  in  1  pulse: regenerate the whole pattern from the LFSR
play  in  1  pulse: play the current pattern (initial show and show_again)
abort  in  1  pulse: stop playback immediately, no done
level  in  3  current level; play length L = min(level+1, MAX_LEN)
seed_load  in  1  pulse: load LFSR with seed
seed  in  8  LFSR seed value
rd_idx  in  $clog2(MAX_LEN)  symbol read index for the checker
rd_sym  out  2  pattern[rd_idx], combinational read
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when playback completes
display  out  3  ROM select: 3'b0ss = digit ss, 3'b100 = intro/idle
clear  out  1  screen-blank request

Behaviour:
- Reset: state IDLE, display=3'b100, clear=0, busy=0, done=0, LFSR=8'hA5, every pattern entry=2'b00, counter=0, idx=0.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifts once per GEN cycle. Symbol = the two LSBs after the shift. seed_load in IDLE loads seed; seed 8'h00 loads 8'hA5. seed_load is ignored outside IDLE.
- States: IDLE, GEN, ON, OFF.
- IDLE: display=3'b100, clear=0. Command priority in the same cycle is new_pattern > play; the lower-priority command is dropped.
- new_pattern in IDLE -> GEN, idx=0.
- GEN: one entry written per cycle, pattern[idx] <= next symbol, idx++. After MAX_LEN cycles -> IDLE with no done. busy is high for exactly MAX_LEN cycles.
- play in IDLE -> ON, idx=0, counter=0. The cycle after play is accepted, display={1'b0,pattern[0]} and clear=0.
- ON: display={1'b0,pattern[idx]}, clear=0, counter++. When counter==ON_CYCLES-1 -> OFF, counter=0.
- OFF: display holds the last symbol, clear=1, counter++. When counter==OFF_CYCLES-1:
  - if idx==L-1 -> IDLE, done=1 for that transition cycle only (done is visible on the first IDLE cycle);
  - else idx++ -> ON.
- Timing: total playback = L*(ON_CYCLES+OFF_CYCLES) cycles from the first ON cycle to the first IDLE cycle.
- level is sampled into L when play is accepted. Changes to level mid-playback have no effect.
- play or new_pattern while busy: ignored, no queuing.
- abort in ON/OFF -> IDLE next cycle: display=3'b100, clear=0, no done. abort in GEN finishes GEN regardless (the pattern is never left partial). abort in IDLE: no effect.
- reset mid-operation: returns to the reset state within one cycle; the pattern is zeroed.
- rd_sym is valid in all states; during GEN it may show a partially updated pattern.
- Counter arithmetic is unsigned CNT_W bits; no wrap is possible by construction.

Decomposition:
- Package game_pkg: display encodings DISP_INTRO=3'b100, DISP_GAMEOVER=3'b101, DISP_WIN=3'b111; the state enum {IDLE, GEN, ON, OFF}; LFSR_DEFAULT_SEED=8'hA5.
- One sub-module, lfsr8 (clk, reset, load, seed, en, q[7:0]), containing the zero-seed substitution.
- The pattern store is a register array inside sequence_presenter (no RAM).

Test Plan:
- Test parameters for all scenarios: MAX_LEN=8, ON_CYCLES=4, OFF_CYCLES=2.
- Reset then idle: hold reset 2 cycles -> display=3'b100, clear=0, busy=0, done=0, rd_sym=0 for every rd_idx 0..7.
- Generation: seed_load with seed=8'h00, then new_pattern -> busy high for exactly 8 cycles. rd_sym for idx 0..7 must equal a reference LFSR model seeded with 8'hA5. Repeating with seed 8'h01 must give a different, model-matching pattern.
- Playback, level=2 (L=3): after play, 3 repetitions of 4 cycles display={0,pattern[i]} with clear=0, then 2 cycles with clear=1. done pulses once, 18 cycles after the first ON cycle; busy then drops.
- Clamp and replay: level=7 -> 8 symbols, 48 cycles. A second play gives an identical display trace. play asserted again mid-run changes nothing.
- Simultaneous and abort: new_pattern and play in the same IDLE cycle -> GEN only, no playback. abort on the 3rd ON cycle -> next cycle display=3'b100, clear=0, done never asserted.
- Reset mid-playback: reset during OFF -> next cycle reset state, the pattern is all 2'b00, and a following play shows digit 0 on every step.
